fetch_stage: RTL and testbench

Instruction-fetch stage of the five-stage MIPS pipeline. It owns the PC register and the IF/ID pipeline register, and it computes the next PC. It consumes the branch-taken decision produced in ID by the branch comparator, plus the jump/jump-register information decoded from the ID-stage instruction. Architectural delay slots are honoured. A wait-state handshake with instruction memory is supported, and a pending-redirect register preserves a taken branch whose delay slot has not yet been fetched.

---
 rtl/fetch_stage_pkg.sv | 31 +++
 rtl/fetch_stage_npc_calc.sv | 30 +++
 rtl/fetch_stage.sv | 74 +++++++
 tb/tb_fetch_stage.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/fetch_stage_pkg.sv
// fetch_stage_pkg: shared opcode/funct constants, reset defaults and IF/ID layout for the fetch stage
package fetch_stage_pkg;
    localparam logic [31:0] RESET_PC_DEF  = 32'h0000_3000;
    localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0000;
    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] OP_REGIMM  = 6'h01;
    localparam logic [5:0] OP_J       = 6'h02;
    localparam logic [5:0] OP_JAL     = 6'h03;
    localparam logic [5:0] OP_BEQ     = 6'h04;
    localparam logic [5:0] OP_BNE     = 6'h05;
    localparam logic [5:0] OP_BLEZ    = 6'h06;
    localparam logic [5:0] OP_BGTZ    = 6'h07;
    localparam logic [4:0] RT_BLTZ    = 5'h00;
    localparam logic [4:0] RT_BGEZ    = 5'h01;
    localparam logic [5:0] FN_JR      = 6'h08;
    localparam logic [5:0] FN_JALR    = 6'h09;
    localparam logic IDLE    = 1'b0;
    localparam logic PENDING = 1'b1;
    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pc8;
        logic        valid;
    } ifid_t;
    function automatic logic is_cond_branch(input logic [31:0] instr);
        logic [5:0] op;
        op = instr[31:26];
        return op == OP_BEQ || op == OP_BNE || op == OP_BLEZ || op == OP_BGTZ ||
               (op == OP_REGIMM && (instr[20:16] == RT_BLTZ || instr[20:16] == RT_BGEZ));
    endfunction
endpackage

// File: rtl/fetch_stage_npc_calc.sv
// npc_calc: ID-stage redirect decode plus branch/jump target and next-PC selection
module npc_calc
    import fetch_stage_pkg::*;
(
    input  logic [31:0] pc_i,
    input  logic [31:0] instr_d_i,
    input  logic [31:0] pc_d_i,
    input  logic        valid_d_i,
    input  logic        branch_i,
    input  logic [31:0] rd1_i,
    input  logic        pend_i,
    input  logic [31:0] pend_target_i,
    output logic        redir_o,
    output logic [31:0] redir_target_o,
    output logic [31:0] npc_o
);
    logic [5:0]  op;
    logic [31:0] pc4_d, br_target, j_target;
    logic        is_br, is_j, is_jr;
    assign op        = instr_d_i[31:26];
    assign pc4_d     = pc_d_i + 32'd4;
    assign br_target = pc4_d + {{14{instr_d_i[15]}}, instr_d_i[15:0], 2'b00};
    assign j_target  = {pc4_d[31:28], instr_d_i[25:0], 2'b00};
    assign is_br     = is_cond_branch(instr_d_i);
    assign is_j      = op == OP_J || op == OP_JAL;
    assign is_jr     = op == OP_SPECIAL && (instr_d_i[5:0] == FN_JR || instr_d_i[5:0] == FN_JALR);
    assign redir_o        = valid_d_i && ((is_br && branch_i) || is_j || is_jr);
    assign redir_target_o = is_jr ? rd1_i : is_j ? j_target : br_target;
    assign npc_o          = redir_o ? redir_target_o : pend_i ? pend_target_i : pc_i + 32'd4;
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: PC, IF/ID register and pending-redirect tracking with delay slots and imem wait states
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = RESET_PC_DEF,
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall_i,
    input  logic        im_ready_i,
    input  logic [31:0] im_instr_i,
    output logic [31:0] im_addr_o,
    input  logic        branch_i,
    input  logic [31:0] rd1_i,
    output logic [31:0] instr_d_o,
    output logic [31:0] pc_d_o,
    output logic [31:0] pc8_d_o,
    output logic        valid_d_o,
    output logic        pend_o
);
    logic [31:0] pc_q, pc_d, pend_target_q, pend_target_d, redir_target, npc;
    logic        pend_q, pend_d, redir;
    ifid_t       ifid_q, ifid_d;
    npc_calc u_npc (
        .pc_i          (pc_q),
        .instr_d_i     (ifid_q.instr),
        .pc_d_i        (ifid_q.pc),
        .valid_d_i     (ifid_q.valid),
        .branch_i      (branch_i),
        .rd1_i         (rd1_i),
        .pend_i        (pend_q == PENDING),
        .pend_target_i (pend_target_q),
        .redir_o       (redir),
        .redir_target_o(redir_target),
        .npc_o         (npc)
    );
    // A redirect seen during a wait state is parked so the delay slot at PC is fetched first
    always_comb begin
        pc_d          = pc_q;
        ifid_d        = ifid_q;
        pend_d        = pend_q;
        pend_target_d = pend_target_q;
        if (!stall_i) begin
            ifid_d = '{instr: im_ready_i ? im_instr_i : NOP_INSTR, pc: pc_q, pc8: pc_q + 32'd8, valid: im_ready_i};
            if (im_ready_i) begin
                pc_d   = npc;
                pend_d = IDLE;
            end else if (redir) begin
                pend_d        = PENDING;
                pend_target_d = redir_target;
            end
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q          <= RESET_PC;
            ifid_q        <= '{instr: NOP_INSTR, pc: 32'd0, pc8: 32'd0, valid: 1'b0};
            pend_q        <= IDLE;
            pend_target_q <= 32'd0;
        end else begin
            pc_q          <= pc_d;
            ifid_q        <= ifid_d;
            pend_q        <= pend_d;
            pend_target_q <= pend_target_d;
        end
    end
    assign im_addr_o = pc_q;
    assign instr_d_o = ifid_q.instr;
    assign pc_d_o    = ifid_q.pc;
    assign pc8_d_o   = ifid_q.pc8;
    assign valid_d_o = ifid_q.valid;
    assign pend_o    = pend_q == PENDING;
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed and randomized checks of fetch_stage against an architectural model
module tb_fetch_stage;
    localparam logic [31:0] NOP  = 32'h0000_0000;
    localparam logic [31:0] BEQ4 = 32'h1022_0004;
    localparam logic [31:0] JR3  = 32'h0060_0008;
    localparam logic [31:0] J10  = 32'h0800_0010;
    logic clk = 1'b0, rst_n = 1'b0, stall_i = 1'b0, im_ready_i = 1'b0, branch_i = 1'b0;
    logic [31:0] im_instr_i = '0, rd1_i = '0;
    logic [31:0] im_addr_o, instr_d_o, pc_d_o, pc8_d_o;
    logic valid_d_o, pend_o;
    int total = 0, bad = 0;
    bit go = 1'b0;
    logic [31:0] m_pc, m_ins, m_pcd, m_pc8, m_ptgt, m_nxt;
    logic m_v, m_pend;
    logic [32:0] m_r;

    fetch_stage dut (
        .clk(clk), .rst_n(rst_n), .stall_i(stall_i), .im_ready_i(im_ready_i), .im_instr_i(im_instr_i),
        .im_addr_o(im_addr_o), .branch_i(branch_i), .rd1_i(rd1_i), .instr_d_o(instr_d_o),
        .pc_d_o(pc_d_o), .pc8_d_o(pc8_d_o), .valid_d_o(valid_d_o), .pend_o(pend_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    // {taken, target} of the instruction sitting in ID
    function automatic logic [32:0] redirect(input logic [31:0] ins, input logic [31:0] pcd, input logic v,
                                             input logic br, input logic [31:0] r1);
        int op = int'(ins[31:26]);
        int rt = int'(ins[20:16]);
        int fn = int'(ins[5:0]);
        logic [31:0] seq = pcd + 32'd4;
        if (!v) return 33'd0;
        if (op inside {4, 5, 6, 7} || (op == 1 && rt inside {0, 1}))
            return {br, seq + 32'($signed(ins[15:0])) * 32'd4};
        if (op == 2 || op == 3) return {1'b1, (seq & 32'hF000_0000) | ({6'd0, ins[25:0]} * 32'd4)};
        if (op == 0 && fn inside {8, 9}) return {1'b1, r1};
        return 33'd0;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pc = 32'h0000_3000; m_ins = NOP; m_pcd = 0; m_pc8 = 0; m_v = 0; m_pend = 0; m_ptgt = 0;
        end else if (!stall_i) begin
            m_r = redirect(m_ins, m_pcd, m_v, branch_i, rd1_i);
            m_pcd = m_pc;
            m_pc8 = m_pc + 32'd8;
            m_v = im_ready_i;
            m_ins = im_ready_i ? im_instr_i : NOP;
            if (im_ready_i) begin
                m_nxt = m_r[32] ? m_r[31:0] : m_pend ? m_ptgt : m_pc + 32'd4;
                m_pc = m_nxt;
                m_pend = 0;
            end else if (m_r[32]) begin
                m_pend = 1;
                m_ptgt = m_r[31:0];
            end
        end
    end

    always @(negedge clk) begin
        if (go) begin
            chk("m_addr", im_addr_o, m_pc);
            chk("m_instr", instr_d_o, m_ins);
            chk("m_pcd", pc_d_o, m_pcd);
            chk("m_pc8", pc8_d_o, m_pc8);
            chk("m_valid", {31'd0, valid_d_o}, {31'd0, m_v});
            chk("m_pend", {31'd0, pend_o}, {31'd0, m_pend});
            chk("pend_bubble", {31'd0, pend_o && valid_d_o}, 32'd0);
        end
    end

    task automatic cyc(input logic st, input logic rdy, input logic br, input logic [31:0] ins, input logic [31:0] r1);
        stall_i = st; im_ready_i = rdy; branch_i = br; im_instr_i = ins; rd1_i = r1;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        stall_i = 0; im_ready_i = 0; branch_i = 0;
        #3 rst_n = 0;
        #1 chk("rst_pend", {31'd0, pend_o}, 32'd0);
        chk("rst_addr", im_addr_o, 32'h0000_3000);
        @(negedge clk);
        #3 rst_n = 1;
        @(negedge clk);
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] w = $urandom;
        case ($urandom_range(0, 9))
            0: w[31:26] = 6'h04;
            1: w[31:26] = 6'h05;
            2: begin w[31:26] = 6'h01; w[20:16] = 5'($urandom_range(0, 3)); end
            3: w[31:26] = 6'h07;
            4: w[31:26] = 6'h06;
            5: w[31:26] = 6'h02;
            6: w[31:26] = 6'h03;
            7: begin w[31:26] = 6'h00; w[5:0] = 6'($urandom_range(0, 2) == 0 ? 8 : $urandom_range(0, 1) ? 9 : 33); end
            default: w[31:26] = 6'($urandom_range(8, 63));
        endcase
        return w;
    endfunction

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_instr", instr_d_o, NOP);
        chk("rst_pcd", pc_d_o, 32'd0);
        chk("rst_pc8", pc8_d_o, 32'd0);
        chk("rst_valid", {31'd0, valid_d_o}, 32'd0);
        chk("rst_addr0", im_addr_o, 32'h0000_3000);
        go = 1'b1;
        #3 rst_n = 1;
        @(negedge clk);
        cyc(0, 1, 0, NOP, 0);
        chk("seq_addr1", im_addr_o, 32'h0000_3004);
        chk("seq_pcd", pc_d_o, 32'h0000_3000);
        chk("seq_pc8", pc8_d_o, 32'h0000_3008);
        chk("seq_valid", {31'd0, valid_d_o}, 32'd1);
        cyc(0, 1, 0, NOP, 0);
        chk("seq_addr2", im_addr_o, 32'h0000_3008);
        do_reset();
        cyc(0, 1, 0, BEQ4, 0);
        chk("beq_slot_addr", im_addr_o, 32'h0000_3004);
        cyc(0, 1, 1, NOP, 0);
        chk("beq_target", im_addr_o, 32'h0000_3014);
        chk("beq_slot_pcd", pc_d_o, 32'h0000_3004);
        cyc(0, 1, 0, JR3, 0);
        for (int i = 0; i < 2; i++) begin
            cyc(0, 0, 0, NOP, 32'h0000_4000);
            chk("jr_wait_pend", {31'd0, pend_o}, 32'd1);
            chk("jr_wait_valid", {31'd0, valid_d_o}, 32'd0);
            chk("jr_wait_addr", im_addr_o, 32'h0000_3018);
        end
        cyc(0, 1, 0, NOP, 0);
        chk("jr_target", im_addr_o, 32'h0000_4000);
        chk("jr_pend_clr", {31'd0, pend_o}, 32'd0);
        chk("jr_slot_pcd", pc_d_o, 32'h0000_3018);
        cyc(0, 1, 0, BEQ4, 0);
        for (int i = 0; i < 3; i++) begin
            cyc(1, i[0], 1, NOP, 0);
            chk("stall_addr", im_addr_o, 32'h0000_4004);
            chk("stall_pcd", pc_d_o, 32'h0000_4000);
            chk("stall_instr", instr_d_o, BEQ4);
            chk("stall_pend", {31'd0, pend_o}, 32'd0);
        end
        cyc(0, 1, 1, NOP, 0);
        chk("stall_redir", im_addr_o, 32'h0000_4014);
        cyc(0, 1, 0, JR3, 0);
        cyc(0, 0, 0, NOP, 32'h0000_5000);
        chk("mid_pend_set", {31'd0, pend_o}, 32'd1);
        do_reset();
        cyc(0, 1, 0, JR3, 0);
        cyc(0, 1, 0, NOP, 32'hF000_0000);
        chk("j_base", im_addr_o, 32'hF000_0000);
        cyc(0, 1, 0, J10, 0);
        cyc(0, 1, 0, NOP, 0);
        chk("j_target", im_addr_o, 32'hF000_0040);
        cyc(0, 1, 0, JR3, 0);
        cyc(0, 1, 0, NOP, 32'hFFFF_FFFC);
        chk("wrap_base", im_addr_o, 32'hFFFF_FFFC);
        cyc(0, 1, 0, NOP, 0);
        chk("wrap_addr", im_addr_o, 32'h0000_0000);
        chk("wrap_pc8", pc8_d_o, 32'h0000_0004);
        for (int n = 0; n < 4000; n++) begin
            if ($urandom_range(0, 199) == 0) do_reset();
            cyc(($urandom_range(0, 3) == 0), ($urandom_range(0, 2) != 0), 1'($urandom), rand_instr(), $urandom);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
